// File: rtl/data_memory_responder_if.sv
// Data-memory request/response bundle between the core (master) and the
// data-memory responder (slave). The access-width type lives in a small
// package so the core, the responder and benches share one definition.
package data_memory_responder_pkg;
    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd3,
        MEM_HU = 3'd4
    } mem_op_t;
endpackage

interface data_memory_responder_if;
    import data_memory_responder_pkg::*;

    logic        mem_wr_en;
    mem_op_t     mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        halted;
    logic [31:0] tohost_data;
    logic        misalign_err;
    logic [31:0] err_addr;

    modport master (
        output mem_wr_en, mem_op, mem_addr, mem_data_in,
        input  mem_data_out, halted, tohost_data, misalign_err, err_addr
    );

    modport slave (
        input  mem_wr_en, mem_op, mem_addr, mem_data_in,
        output mem_data_out, halted, tohost_data, misalign_err, err_addr
    );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: word-organised RAM with byte/half/word lane
// steering and load extension, plus a 16-byte MMIO window holding a 64-bit
// cycle counter, the tohost halt register and a scratch register.
// Loads are combinational; stores and all state change on the rising edge.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter string INIT_FILE = ""
) (
    input logic clk,
    input logic reset,
    data_memory_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   ram [DEPTH_WORDS];

    logic [63:0]   counter;
    logic          halted_q;
    logic [31:0]   tohost_q;
    logic [31:0]   scratch_q;
    logic          misalign_q;
    logic [31:0]   err_addr_q;

    logic          is_mmio;
    logic          is_word;
    logic          misaligned;
    logic          store_ok;
    logic          ram_we;
    logic          tohost_we;
    logic          scratch_we;
    logic [3:0]    byte_en;
    logic [31:0]   wr_word;
    logic [AW-1:0] word_idx;
    logic [31:0]   ram_word;
    logic [31:0]   mmio_word;
    logic [31:0]   load_data;

    // Pick the addressed byte/half from a RAM word and sign/zero extend it.
    function automatic logic [31:0] extend_load(mem_op_t op, logic [1:0] lane,
                                                logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            MEM_B:   return {{24{b[7]}}, b};
            MEM_BU:  return {24'd0, b};
            MEM_H:   return {{16{h[15]}}, h};
            MEM_HU:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    // Decode the request: region, alignment, byte enables and write strobes.
    always_comb begin
        is_mmio    = (bus.mem_addr[31:4] == MMIO_BASE[31:4]);
        word_idx   = bus.mem_addr[AW+1:2];
        is_word    = 1'b0;
        misaligned = 1'b0;
        byte_en    = 4'b1111;
        wr_word    = bus.mem_data_in;
        case (bus.mem_op)
            MEM_B, MEM_BU: begin
                byte_en = 4'b0001 << bus.mem_addr[1:0];
                wr_word = {4{bus.mem_data_in[7:0]}};
            end
            MEM_H, MEM_HU: begin
                misaligned = bus.mem_addr[0];
                byte_en    = bus.mem_addr[1] ? 4'b1100 : 4'b0011;
                wr_word    = {2{bus.mem_data_in[15:0]}};
            end
            default: begin
                // Unused encodings behave as a full word access.
                is_word    = 1'b1;
                misaligned = (bus.mem_addr[1:0] != 2'd0);
            end
        endcase
        // The MMIO registers only accept full-word accesses.
        if (is_mmio && !is_word) begin
            misaligned = 1'b1;
        end
        store_ok   = bus.mem_wr_en && !misaligned && !halted_q;
        ram_we     = store_ok && !is_mmio;
        tohost_we  = store_ok && is_mmio && (bus.mem_addr[3:2] == 2'd2);
        scratch_we = store_ok && is_mmio && (bus.mem_addr[3:2] == 2'd3);
    end

    // Load path: registered state only, so a store shows pre-write data.
    always_comb begin
        ram_word = ram[word_idx];
        case (bus.mem_addr[3:2])
            2'd0:    mmio_word = counter[31:0];
            2'd1:    mmio_word = counter[63:32];
            2'd2:    mmio_word = tohost_q;
            default: mmio_word = scratch_q;
        endcase
        if (misaligned) begin
            load_data = 32'd0;
        end else if (is_mmio) begin
            load_data = mmio_word;
        end else begin
            load_data = extend_load(bus.mem_op, bus.mem_addr[1:0], ram_word);
        end
    end

    // RAM byte-lane writes; never reset, and a store during reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    ram[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    // Counter, MMIO registers and sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter    <= 64'd0;
            halted_q   <= 1'b0;
            tohost_q   <= 32'd0;
            scratch_q  <= 32'd0;
            misalign_q <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            // The counter stops at the edge that sets halted, and stays put.
            if (!halted_q && !tohost_we) begin
                counter <= counter + 64'd1;
            end
            if (tohost_we) begin
                tohost_q <= bus.mem_data_in;
                halted_q <= 1'b1;
            end
            if (scratch_we) begin
                scratch_q <= bus.mem_data_in;
            end
            // Only the first misaligned address is kept.
            if (misaligned && !misalign_q) begin
                misalign_q <= 1'b1;
                err_addr_q <= bus.mem_addr;
            end
        end
    end

    assign bus.mem_data_out = load_data;
    assign bus.halted       = halted_q;
    assign bus.tohost_data  = tohost_q;
    assign bus.misalign_err = misalign_q;
    assign bus.err_addr     = err_addr_q;

endmodule
